// File: rtl/reorder_buffer_if.sv
// rtl/reorder_buffer_if.sv - rename/writeback/retire bundle between the pipeline and the ROB
interface reorder_buffer_if #(
    parameter int TAG_W = 4
);
    logic             alloc_valid_1;
    logic             alloc_valid_2;
    logic [4:0]       alloc_rd_1;
    logic [4:0]       alloc_rd_2;
    logic             alloc_has_rd_1;
    logic             alloc_has_rd_2;
    logic [5:0]       alloc_new_preg_1;
    logic [5:0]       alloc_new_preg_2;
    logic [5:0]       alloc_old_preg_1;
    logic [5:0]       alloc_old_preg_2;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag_1;
    logic [TAG_W-1:0] alloc_tag_2;

    logic             cmpl_valid_a;
    logic             cmpl_valid_b;
    logic [TAG_W-1:0] cmpl_tag_a;
    logic [TAG_W-1:0] cmpl_tag_b;
    logic             flush;

    logic             rob_commit;
    logic             rob_retire_valid;
    logic [5:0]       rob_retire_preg;
    logic [4:0]       rob_retire_rd;
    logic [TAG_W:0]   rob_count;
    logic             rob_empty;
    logic             rob_full;

    modport master (
        output alloc_valid_1, alloc_valid_2, alloc_rd_1, alloc_rd_2,
               alloc_has_rd_1, alloc_has_rd_2, alloc_new_preg_1, alloc_new_preg_2,
               alloc_old_preg_1, alloc_old_preg_2,
               cmpl_valid_a, cmpl_valid_b, cmpl_tag_a, cmpl_tag_b, flush,
        input  alloc_ready, alloc_tag_1, alloc_tag_2,
               rob_commit, rob_retire_valid, rob_retire_preg, rob_retire_rd,
               rob_count, rob_empty, rob_full
    );

    modport slave (
        input  alloc_valid_1, alloc_valid_2, alloc_rd_1, alloc_rd_2,
               alloc_has_rd_1, alloc_has_rd_2, alloc_new_preg_1, alloc_new_preg_2,
               alloc_old_preg_1, alloc_old_preg_2,
               cmpl_valid_a, cmpl_valid_b, cmpl_tag_a, cmpl_tag_b, flush,
        output alloc_ready, alloc_tag_1, alloc_tag_2,
               rob_commit, rob_retire_valid, rob_retire_preg, rob_retire_rd,
               rob_count, rob_empty, rob_full
    );
endinterface

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - dual-allocate, dual-complete, single-retire in-order reorder buffer
module reorder_buffer #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 4
) (
    input logic             clk,
    input logic             rst,
    reorder_buffer_if.slave rob
);
    localparam logic [TAG_W:0] FREE2_LIMIT = (TAG_W+1)'(DEPTH - 2);
    localparam logic [TAG_W:0] DEPTH_C     = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [DEPTH-1:0]      done_q, done_d;
    logic [DEPTH-1:0]      has_rd_q, has_rd_d;
    logic [DEPTH-1:0][4:0] rd_q, rd_d;
    logic [DEPTH-1:0][5:0] new_preg_q, new_preg_d;
    logic [DEPTH-1:0][5:0] old_preg_q, old_preg_d;
    logic [TAG_W-1:0]      head_q, head_d;
    logic [TAG_W-1:0]      tail_q, tail_d;
    logic [TAG_W:0]        count_q, count_d;
    logic                  commit_q, commit_d;
    logic                  ret_valid_q, ret_valid_d;
    logic [5:0]            ret_preg_q, ret_preg_d;
    logic [4:0]            ret_rd_q, ret_rd_d;

    logic                  alloc_ok;
    logic                  take_1;
    logic                  take_2;
    logic                  retire;
    logic [1:0]            n_alloc;
    logic [TAG_W-1:0]      slot2_idx;

    // Readiness looks only at registered occupancy so it never depends on this cycle's retire.
    assign alloc_ok             = (count_q <= FREE2_LIMIT);
    assign rob.alloc_ready      = alloc_ok;
    assign rob.alloc_tag_1      = tail_q;
    assign rob.alloc_tag_2      = tail_q + 1'b1;
    assign rob.rob_count        = count_q;
    assign rob.rob_empty        = (count_q == '0);
    assign rob.rob_full         = (count_q == DEPTH_C);
    assign rob.rob_commit       = commit_q;
    assign rob.rob_retire_valid = ret_valid_q;
    assign rob.rob_retire_preg  = ret_preg_q;
    assign rob.rob_retire_rd    = ret_rd_q;

    always_comb begin
        valid_d     = valid_q;
        done_d      = done_q;
        has_rd_d    = has_rd_q;
        rd_d        = rd_q;
        new_preg_d  = new_preg_q;
        old_preg_d  = old_preg_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        commit_d    = 1'b0;
        ret_valid_d = 1'b0;
        ret_preg_d  = ret_preg_q;
        ret_rd_d    = ret_rd_q;

        take_1    = alloc_ok & rob.alloc_valid_1;
        take_2    = alloc_ok & rob.alloc_valid_2;
        n_alloc   = {1'b0, take_1} + {1'b0, take_2};
        slot2_idx = take_1 ? tail_q + 1'b1 : tail_q;
        retire    = valid_q[head_q] & done_q[head_q];

        if (rob.flush) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Completions see registered valid bits, so same-cycle allocations are not marked.
            if (rob.cmpl_valid_a && valid_q[rob.cmpl_tag_a]) begin
                done_d[rob.cmpl_tag_a] = 1'b1;
            end
            if (rob.cmpl_valid_b && valid_q[rob.cmpl_tag_b]) begin
                done_d[rob.cmpl_tag_b] = 1'b1;
            end

            if (retire) begin
                commit_d        = 1'b1;
                ret_valid_d     = has_rd_q[head_q];
                ret_preg_d      = old_preg_q[head_q];
                ret_rd_d        = rd_q[head_q];
                valid_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                head_d          = head_q + 1'b1;
            end

            if (take_1) begin
                valid_d[tail_q]    = 1'b1;
                done_d[tail_q]     = 1'b0;
                has_rd_d[tail_q]   = rob.alloc_has_rd_1;
                rd_d[tail_q]       = rob.alloc_rd_1;
                new_preg_d[tail_q] = rob.alloc_new_preg_1;
                old_preg_d[tail_q] = rob.alloc_old_preg_1;
            end
            if (take_2) begin
                valid_d[slot2_idx]    = 1'b1;
                done_d[slot2_idx]     = 1'b0;
                has_rd_d[slot2_idx]   = rob.alloc_has_rd_2;
                rd_d[slot2_idx]       = rob.alloc_rd_2;
                new_preg_d[slot2_idx] = rob.alloc_new_preg_2;
                old_preg_d[slot2_idx] = rob.alloc_old_preg_2;
            end

            tail_d  = tail_q + TAG_W'(n_alloc);
            count_d = count_q + (TAG_W+1)'(n_alloc) - (TAG_W+1)'(retire);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= '0;
            done_q      <= '0;
            has_rd_q    <= '0;
            rd_q        <= '0;
            new_preg_q  <= '0;
            old_preg_q  <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            commit_q    <= 1'b0;
            ret_valid_q <= 1'b0;
            ret_preg_q  <= '0;
            ret_rd_q    <= '0;
        end else begin
            valid_q     <= valid_d;
            done_q      <= done_d;
            has_rd_q    <= has_rd_d;
            rd_q        <= rd_d;
            new_preg_q  <= new_preg_d;
            old_preg_q  <= old_preg_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            commit_q    <= commit_d;
            ret_valid_q <= ret_valid_d;
            ret_preg_q  <= ret_preg_d;
            ret_rd_q    <= ret_rd_d;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed and randomized checks of reorder_buffer against a queue model
module tb_reorder_buffer;
    localparam int DEPTH = 16;
    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    reorder_buffer_if #(.TAG_W(TAG_W)) bus ();

    reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .rob (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rd;
        logic       has_rd;
        logic [5:0] old_preg;
        logic       done;
    } ent_t;

    ent_t       mq[$];
    int         m_head;
    logic [5:0] m_preg;
    logic [4:0] m_rd;
    logic       m_commit;
    logic       m_rv;
    int         n_total = 0;
    int         n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    endtask

    task automatic check_all(input string ph);
        int sz = mq.size();
        chk({ph, ":count"},  32'(bus.rob_count), 32'(sz));
        chk({ph, ":ready"},  32'(bus.alloc_ready), 32'((DEPTH - sz) >= 2));
        chk({ph, ":empty"},  32'(bus.rob_empty), 32'(sz == 0));
        chk({ph, ":full"},   32'(bus.rob_full), 32'(sz == DEPTH));
        chk({ph, ":tag1"},   32'(bus.alloc_tag_1), 32'((m_head + sz) % DEPTH));
        chk({ph, ":tag2"},   32'(bus.alloc_tag_2), 32'((m_head + sz + 1) % DEPTH));
        chk({ph, ":commit"}, 32'(bus.rob_commit), 32'(m_commit));
        chk({ph, ":rvalid"}, 32'(bus.rob_retire_valid), 32'(m_rv));
        chk({ph, ":preg"},   32'(bus.rob_retire_preg), 32'(m_preg));
        chk({ph, ":rd"},     32'(bus.rob_retire_rd), 32'(m_rd));
    endtask

    task automatic model_reset();
        mq.delete();
        m_head   = 0;
        m_preg   = '0;
        m_rd     = '0;
        m_commit = 1'b0;
        m_rv     = 1'b0;
    endtask

    task automatic mark_done(input int tag, input int old_sz);
        int   idx = (tag - m_head + DEPTH) % DEPTH;
        ent_t e;
        if (idx < old_sz) begin
            e      = mq[idx];
            e.done = 1'b1;
            mq[idx] = e;
        end
    endtask

    task automatic idle();
        bus.alloc_valid_1    = 1'b0;
        bus.alloc_valid_2    = 1'b0;
        bus.alloc_rd_1       = '0;
        bus.alloc_rd_2       = '0;
        bus.alloc_has_rd_1   = 1'b0;
        bus.alloc_has_rd_2   = 1'b0;
        bus.alloc_new_preg_1 = '0;
        bus.alloc_new_preg_2 = '0;
        bus.alloc_old_preg_1 = '0;
        bus.alloc_old_preg_2 = '0;
        bus.cmpl_valid_a     = 1'b0;
        bus.cmpl_valid_b     = 1'b0;
        bus.cmpl_tag_a       = '0;
        bus.cmpl_tag_b       = '0;
        bus.flush            = 1'b0;
    endtask

    task automatic set_alloc(input int slot, input bit v, input bit has, input int rd,
                             input int oldp, input int newp);
        if (slot == 1) begin
            bus.alloc_valid_1    = v;
            bus.alloc_has_rd_1   = has;
            bus.alloc_rd_1       = 5'(rd);
            bus.alloc_old_preg_1 = 6'(oldp);
            bus.alloc_new_preg_1 = 6'(newp);
        end else begin
            bus.alloc_valid_2    = v;
            bus.alloc_has_rd_2   = has;
            bus.alloc_rd_2       = 5'(rd);
            bus.alloc_old_preg_2 = 6'(oldp);
            bus.alloc_new_preg_2 = 6'(newp);
        end
    endtask

    task automatic step(input string ph);
        int sz    = mq.size();
        bit ready = (DEPTH - sz) >= 2;
        bit ret;
        if (bus.flush) begin
            mq.delete();
            m_head   = 0;
            m_commit = 1'b0;
            m_rv     = 1'b0;
        end else begin
            ret = (sz > 0) && mq[0].done;
            if (bus.cmpl_valid_a) mark_done(int'(bus.cmpl_tag_a), sz);
            if (bus.cmpl_valid_b) mark_done(int'(bus.cmpl_tag_b), sz);
            m_commit = ret;
            m_rv     = 1'b0;
            if (ret) begin
                m_rv   = mq[0].has_rd;
                m_preg = mq[0].old_preg;
                m_rd   = mq[0].rd;
                void'(mq.pop_front());
                m_head = (m_head + 1) % DEPTH;
            end
            if (ready && bus.alloc_valid_1)
                mq.push_back('{bus.alloc_rd_1, bus.alloc_has_rd_1, bus.alloc_old_preg_1, 1'b0});
            if (ready && bus.alloc_valid_2)
                mq.push_back('{bus.alloc_rd_2, bus.alloc_has_rd_2, bus.alloc_old_preg_2, 1'b0});
        end
        @(posedge clk);
        #1;
        check_all(ph);
    endtask

    task automatic rand_alloc(input int slot, input int pct);
        set_alloc(slot, $urandom_range(0, 99) < pct, 1'($urandom), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
    endtask

    initial begin
        idle();
        model_reset();
        rst = 1'b0;
        #2;
        check_all("reset_low");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        check_all("reset");
        chk("reset_tag2", 32'(bus.alloc_tag_2), 32'd1);

        // Dual allocation, then out-of-order completion.
        set_alloc(1, 1'b1, 1'b1, 3, 3, 33);
        set_alloc(2, 1'b1, 1'b1, 5, 5, 34);
        step("dual_alloc");
        chk("dual_count", 32'(bus.rob_count), 32'd2);
        idle();
        bus.cmpl_valid_a = 1'b1;
        bus.cmpl_tag_a   = 4'd1;
        step("cmpl_tag1");
        idle();
        step("wait_tag0");
        chk("no_early_retire", 32'(bus.rob_commit), 32'd0);
        bus.cmpl_valid_b = 1'b1;
        bus.cmpl_tag_b   = 4'd0;
        step("cmpl_tag0");
        chk("same_cycle_no_retire", 32'(bus.rob_commit), 32'd0);
        idle();
        step("retire_tag0");
        chk("ret0_commit", 32'(bus.rob_commit), 32'd1);
        chk("ret0_preg", 32'(bus.rob_retire_preg), 32'd3);
        chk("ret0_rd", 32'(bus.rob_retire_rd), 32'd3);
        step("retire_tag1");
        chk("ret1_preg", 32'(bus.rob_retire_preg), 32'd5);
        step("drained");

        // Instruction without a destination register.
        set_alloc(1, 1'b1, 1'b0, 0, 9, 7);
        step("alloc_nord");
        idle();
        bus.cmpl_valid_a = 1'b1;
        bus.cmpl_tag_a   = TAG_W'(m_head);
        step("cmpl_nord");
        idle();
        step("retire_nord");
        chk("nord_commit", 32'(bus.rob_commit), 32'd1);
        chk("nord_rvalid", 32'(bus.rob_retire_valid), 32'd0);

        // Fill to capacity; the ninth pair must be ignored.
        for (int i = 0; i < 9; i++) begin
            rand_alloc(1, 100);
            rand_alloc(2, 100);
            step("fill");
        end
        chk("full_flag", 32'(bus.rob_full), 32'd1);
        chk("full_count", 32'(bus.rob_count), 32'd16);
        idle();
        bus.cmpl_valid_a = 1'b1;
        bus.cmpl_tag_a   = TAG_W'(m_head);
        step("cmpl_at_full");
        idle();
        step("retire_from_full");
        chk("count15", 32'(bus.rob_count), 32'd15);
        chk("ready_at15", 32'(bus.alloc_ready), 32'd0);
        rand_alloc(1, 100);
        rand_alloc(2, 100);
        step("alloc_at15");

        // Flush with six entries, a pending retire and concurrent alloc/completion.
        idle();
        bus.flush = 1'b1;
        step("flush_full");
        idle();
        for (int i = 0; i < 3; i++) begin
            rand_alloc(1, 100);
            rand_alloc(2, 100);
            step("alloc_six");
        end
        idle();
        bus.cmpl_valid_a = 1'b1;
        bus.cmpl_tag_a   = TAG_W'(m_head);
        step("cmpl_before_flush");
        rand_alloc(1, 100);
        rand_alloc(2, 100);
        bus.cmpl_valid_b = 1'b1;
        bus.cmpl_tag_b   = TAG_W'(m_head + 1);
        bus.flush        = 1'b1;
        step("flush_six");
        chk("flush_empty", 32'(bus.rob_empty), 32'd1);
        chk("flush_commit", 32'(bus.rob_commit), 32'd0);

        // Random traffic: a heavy-allocation phase followed by a draining phase.
        for (int c = 0; c < 600; c++) begin
            int pct = (c < 300) ? 75 : 25;
            idle();
            rand_alloc(1, pct);
            rand_alloc(2, pct);
            if ($urandom_range(0, 99) < 70) begin
                bus.cmpl_valid_a = 1'b1;
                if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                    bus.cmpl_tag_a = TAG_W'((m_head + int'($urandom_range(0, mq.size() - 1))) % DEPTH);
                else
                    bus.cmpl_tag_a = TAG_W'($urandom_range(0, DEPTH - 1));
            end
            if ($urandom_range(0, 99) < 50) begin
                bus.cmpl_valid_b = 1'b1;
                if (mq.size() > 0)
                    bus.cmpl_tag_b = TAG_W'((m_head + int'($urandom_range(0, mq.size() - 1))) % DEPTH);
                else
                    bus.cmpl_tag_b = TAG_W'($urandom_range(0, DEPTH - 1));
            end
            bus.flush = ($urandom_range(0, 199) == 0);
            step("random");
        end

        // Asynchronous reset in the middle of a cycle.
        idle();
        for (int i = 0; i < 3; i++) begin
            rand_alloc(1, 100);
            rand_alloc(2, 100);
            bus.cmpl_valid_a = 1'b1;
            bus.cmpl_tag_a   = TAG_W'(m_head);
            step("pre_reset");
        end
        idle();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(posedge clk);
        #1;
        check_all("reset_held");
        rst = 1'b1;
        step("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, 16, number of ROB entries (power of two).
REQ-002 SHALL have parameter TAG_W, 4, entry index width (log2 DEPTH).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports alloc_valid_1 / alloc_valid_2  input  1  rename slot 1/2 presents an instruction.
REQ-006 SHALL have ports alloc_rd_1 / alloc_rd_2  input  5  architectural destination.
REQ-007 SHALL have ports alloc_has_rd_1 / alloc_has_rd_2  input  1  instruction writes a register (rd != x0).
REQ-008 SHALL have ports alloc_new_preg_1 / alloc_new_preg_2  input  6  physical register assigned by rename.
REQ-009 SHALL have ports alloc_old_preg_1 / alloc_old_preg_2  input  6  previous mapping, freed at retire.
REQ-010 SHALL have port alloc_ready  output  1  at least 2 free entries; combinational from registered count.
REQ-011 SHALL have ports alloc_tag_1 / alloc_tag_2  output  TAG_W  tail and tail+1 (mod DEPTH), combinational.
REQ-012 SHALL have ports cmpl_valid_a / cmpl_valid_b  input  1  execution writeback ports A/B.
REQ-013 SHALL have ports cmpl_tag_a / cmpl_tag_b  input  TAG_W  ROB tag completing.
REQ-014 SHALL have port flush  input  1  discard all entries.
REQ-015 SHALL have port rob_commit  output  1  registered; one instruction retired last edge.
REQ-016 SHALL have port rob_retire_valid  output  1  registered; retired instruction had has_rd=1, old preg to free.
REQ-017 SHALL have ports rob_retire_preg  output  6  and rob_retire_rd  output  5  registered; old preg and rd of retired entry.
REQ-018 SHALL have ports rob_count  output  TAG_W+1, rob_empty  output  1, rob_full  output  1  occupancy status.

Function
REQ-019 Entry state: valid, done, has_rd, rd, new_preg, old_preg; head, tail pointers TAG_W bits, wrap mod DEPTH; count 0..DEPTH.
REQ-020 Allocation SHALL occur only when alloc_ready=1; slot 1 writes entry tail, slot 2 writes tail+1 if slot 1 also valid, else tail.
REQ-021 Allocated entries: valid=1, done=0; tail advances by number allocated (0,1,2).
REQ-022 alloc_valid_* while alloc_ready=0 SHALL be ignored, no state change.
REQ-023 Completion on a valid entry SHALL set done=1 at the edge; completion on an invalid entry SHALL be ignored; both ports to same tag is legal.
REQ-024 Retire: if head entry valid and done, at the edge clear it, head+1, rob_commit=1, rob_retire_valid=has_rd, rob_retire_preg=old_preg, rob_retire_rd=rd; else rob_commit=rob_retire_valid=0 (preg/rd hold).
REQ-025 Maximum one retirement per cycle; strictly in program (head) order.
REQ-026 Completion arriving the same cycle head is checked SHALL not retire that cycle (done sampled from registered state); retires next cycle.
REQ-027 Simultaneous alloc and retire: count_next = count + n_alloc - n_retire; alloc_ready uses current count (DEPTH-count >= 2).
REQ-028 rob_empty = (count==0); rob_full = (count==DEPTH); with one free entry alloc_ready=0.
REQ-029 flush SHALL take priority: at the edge clear all valid bits, head=tail=count=0, rob_commit=rob_retire_valid=0; alloc/cmpl that cycle ignored.

Reset
REQ-030 rst low SHALL immediately clear all valid/done bits, head=tail=count=0, rob_commit=0, rob_retire_valid=0, rob_retire_preg=0, rob_retire_rd=0.
REQ-031 After reset: rob_empty=1, rob_full=0, alloc_ready=1, alloc_tag_1=0, alloc_tag_2=1; reset mid-operation discards all entries.

Verification
REQ-032 Dual alloc (rd 3/5, new 33/34, old 3/5) at empty -> tags 0/1, count=2; cmpl tag 0 -> next edge rob_commit=1, retire_valid=1, preg=3, rd=3.
REQ-033 Complete tag 1 before tag 0 -> no retire until tag 0 done; then retire tag 0, next cycle tag 1 (preg=5).
REQ-034 Allocate 16 entries -> rob_full=1, alloc_ready=0 at count 15; further alloc_valid ignored, count stays 16.
REQ-035 Fill/drain 20 entries -> tail/head wrap 15->0; retire order matches alloc order, old_preg values intact.
REQ-036 has_rd=0 entry done at head -> rob_commit=1, rob_retire_valid=0.
REQ-037 flush with 6 entries and concurrent alloc -> next cycle count=0, rob_empty=1, no commit; rst low mid-run -> outputs 0 asynchronously.
